// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
// Shared definitions for the iterative integer divider (div_iter / div_step).
//   op_e          : operation encoding as seen on op_i
//                   (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   state_e       : control FSM states
//   calc_cycles() : number of CALC cycles for a given width / radix
//   op_is_signed(), op_is_rem() : decode helpers for op_e
// -----------------------------------------------------------------------------
package div_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    // Each CALC cycle retires bpc quotient bits, so a full division takes
    // xlen/bpc cycles in CALC.
    function automatic int calc_cycles(input int xlen, input int bpc);
        return xlen / bpc;
    endfunction

    // Bit 0 clear selects the signed flavour (DIV, REM).
    function automatic logic op_is_signed(input op_e op);
        return ~op[0];
    endfunction

    // Bit 1 set selects the remainder as the result (REM, REMU).
    function automatic logic op_is_rem(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// Purely combinational radix-2^BITS_PER_CYCLE restoring division slice.
// Chains BITS_PER_CYCLE shift/compare/subtract stages on the pair
// {remainder, quotient}. The quotient register starts out holding the
// dividend magnitude; each stage shifts its MSB into the remainder and shifts
// a new quotient bit into its LSB.
//
// Ports:
//   i_rem  [XLEN-1:0]  partial remainder entering the cycle (always < i_div)
//   i_quo  [XLEN-1:0]  remaining dividend bits / quotient bits so far
//   i_div  [XLEN-1:0]  divisor magnitude (non-zero)
//   o_rem  [XLEN-1:0]  partial remainder after BITS_PER_CYCLE stages
//   o_quo  [XLEN-1:0]  quotient register after BITS_PER_CYCLE stages
// -----------------------------------------------------------------------------
module div_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN-1:0] w_rem [0:BITS_PER_CYCLE];
    logic [XLEN-1:0] w_quo [0:BITS_PER_CYCLE];

    assign w_rem[0] = i_rem;
    assign w_quo[0] = i_quo;

    for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_stage
        logic [XLEN:0] w_shift;
        logic [XLEN:0] w_diff;
        logic          w_fits;

        // The shifted partial remainder needs XLEN+1 bits. Because the
        // incoming remainder is below the divisor, the difference is either
        // below the divisor (fits) or negative, and its MSB is then set.
        assign w_shift = {w_rem[k], w_quo[k][XLEN-1]};
        assign w_diff  = w_shift - {1'b0, i_div};
        assign w_fits  = ~w_diff[XLEN];

        // Either choice is below the divisor, so dropping the top bit is safe.
        assign w_rem[k+1] = w_fits ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
        assign w_quo[k+1] = {w_quo[k][XLEN-2:0], w_fits};
    end

    assign o_rem = w_rem[BITS_PER_CYCLE];
    assign o_quo = w_quo[BITS_PER_CYCLE];

endmodule

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Multi-cycle iterative integer divider for the RV32/RV64 M extension.
// Supports DIV, DIVU, REM and REMU with RISC-V semantics for division by
// zero and signed overflow. Operates on magnitudes and applies the sign
// correction in a dedicated FIX cycle.
//
// Flow: IDLE --accept--> CALC (N cycles) -> FIX -> DONE -> IDLE
//       IDLE --accept, b==0 or overflow--> DONE -> IDLE
// result_o and ready_o are registered on the edge that leaves DONE, so the
// ready pulse coincides with the following IDLE cycle, which is also the
// cycle in which a held req_i is accepted again.
//
// Parameters:
//   XLEN            operand/result width (32 or 64)
//   BITS_PER_CYCLE  quotient bits retired per CALC cycle (1, 2 or 4)
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     asynchronous active-high reset
//   a_i       dividend, sampled on accept
//   b_i       divisor, sampled on accept
//   op_i      operation (op_e), sampled on accept
//   req_i     request, accepted in IDLE when kill_i is low
//   kill_i    abort; returns to IDLE from IDLE/CALC/FIX, ignored in DONE
//   busy_o    high whenever the FSM is not in IDLE
//   ready_o   one-cycle completion pulse
//   result_o  quotient or remainder, held until the next completion
// -----------------------------------------------------------------------------
module div_iter
    import div_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [1:0]      op_i,
    input  logic            req_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    localparam int              N        = calc_cycles(XLEN, BITS_PER_CYCLE);
    localparam int              CNT_W    = $clog2(N + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           r_state;
    state_e           w_next_state;
    op_e              r_op;
    logic             r_neg_q;      // quotient must be negated in FIX
    logic             r_neg_r;      // remainder must be negated in FIX
    logic [XLEN-1:0]  r_quo;        // dividend bits in, quotient bits out
    logic [XLEN-1:0]  r_rem;        // partial remainder
    logic [XLEN-1:0]  r_div;        // divisor magnitude
    logic [CNT_W-1:0] r_cnt;        // CALC cycles remaining
    logic [XLEN-1:0]  r_result;
    logic             r_ready;

    // ------------------------------------------------------------------
    // Operand decode, only meaningful on the accept edge
    // ------------------------------------------------------------------
    op_e             w_op;
    logic            w_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_abs;
    logic [XLEN-1:0] w_b_abs;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic            w_accept;

    assign w_op     = op_e'(op_i);
    assign w_signed = op_is_signed(w_op);
    assign w_a_neg  = w_signed & a_i[XLEN-1];
    assign w_b_neg  = w_signed & b_i[XLEN-1];

    // Negating MOST_NEG wraps to itself, which is still its correct
    // magnitude when read as unsigned.
    assign w_a_abs  = w_a_neg ? -a_i : a_i;
    assign w_b_abs  = w_b_neg ? -b_i : b_i;

    assign w_div_zero = (b_i == '0);
    assign w_overflow = w_signed && (a_i == MOST_NEG) && (b_i == '1);
    assign w_special  = w_div_zero | w_overflow;

    // ------------------------------------------------------------------
    // One restoring slice per CALC cycle
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;

    div_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_step_rem),
        .o_quo (w_step_quo)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples pre-edge values regardless of process order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path assigned,
    // so no latch is inferred for w_next_state.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_i && !kill_i) begin
                    w_next_state = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (kill_i) begin
                    w_next_state = S_IDLE;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = kill_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                // A kill here is deliberately ignored: the result is final.
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        busy_o   = (r_state != S_IDLE);
        w_accept = (r_state == S_IDLE) && req_i && !kill_i;
    end

    assign ready_o  = r_ready;
    assign result_o = r_result;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // NOTE: every datapath register is cleared by reset; none of them is a
    // memory array, so this costs nothing and keeps result_o defined.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_op     <= OP_DIV;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_ready <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_div <= w_b_abs;
                        r_cnt <= CNT_W'(N);
                        if (w_special) begin
                            // Results are final here; FIX is skipped.
                            // b==0: q = all-ones, r = a.  Overflow: q = a, r = 0.
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_quo   <= w_div_zero ? '1  : a_i;
                            r_rem   <= w_div_zero ? a_i : '0;
                        end else begin
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                            r_quo   <= w_a_abs;
                            r_rem   <= '0;
                        end
                    end
                end
                S_CALC: begin
                    r_quo <= w_step_quo;
                    r_rem <= w_step_rem;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                S_FIX: begin
                    // Quotient sign is the XOR of operand signs; remainder
                    // sign follows the dividend.
                    if (r_neg_q) begin
                        r_quo <= -r_quo;
                    end
                    if (r_neg_r) begin
                        r_rem <= -r_rem;
                    end
                end
                S_DONE: begin
                    r_result <= op_is_rem(r_op) ? r_rem : r_quo;
                    r_ready  <= 1'b1;
                end
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
